// File: rtl/seg7_scan4.sv
// ---------------------------------------------------------------------------
// seg7_scan4 - 4-digit multiplexed common-anode 7-segment scanner
//
// Shows the four lab nibbles (CNT_VHDL, OUT_VHDL, CNT_VLOG, OUT_VLOG) on a
// 4-digit display. Each digit slot lasts DIV clocks. The first clock of a
// slot is blanked (all anodes off) to suppress ghosting. All four nibbles
// are captured together once per frame, so one frame never mixes old and
// new values.
//
// Parameters:
//   DIV  clocks per digit slot (2 .. 2^20)
//   PW   prescaler width, 2^PW >= DIV
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   EN     in   scan enable; 0 freezes the scan and blanks the anodes
//   D0..D3 in   digit values 0..3 (4 bits each)
//   AN     out  digit anodes, active-low, registered
//   SEG    out  segments {g,f,e,d,c,b,a}, active-low, registered
//   DP     out  decimal point, active-low, registered
//   FRAME  out  one-cycle pulse after each snapshot load
//
// Optional build macro:
//   SEG7_MISMATCH_DP_EN  lights DP on every lit digit while the last
//                        snapshot had D0!=D2 or D1!=D3. Undefined: DP is 1.
// ---------------------------------------------------------------------------
module seg7_scan4 #(
    parameter int DIV = 16,
    parameter int PW  = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap0_q, snap0_d;
    logic [3:0]    snap1_q, snap1_d;
    logic [3:0]    snap2_q, snap2_d;
    logic [3:0]    snap3_q, snap3_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;
    logic          blank_q, blank_d;
`ifdef SEG7_MISMATCH_DP_EN
    logic          mism_q, mism_d;
`endif

    logic          tick;
    logic          snap_load;
    logic [3:0]    digit_sel;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = EN && (pcnt_q == PCNT_MAX);
        snap_load = tick && (idx_q == 2'd3);

        pcnt_d = pcnt_q;
        if (EN) begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
        end

        idx_d = tick ? idx_q + 2'd1 : idx_q;

        snap0_d = snap_load ? D0 : snap0_q;
        snap1_d = snap_load ? D1 : snap1_q;
        snap2_d = snap_load ? D2 : snap2_q;
        snap3_d = snap_load ? D3 : snap3_q;

        frame_d = snap_load;
        blank_d = tick;

        // Select from the next-state snapshot so that a wrap to digit 0 on
        // a snapshot tick already shows the freshly captured D0.
        case (idx_d)
            2'd0:    digit_sel = snap0_d;
            2'd1:    digit_sel = snap1_d;
            2'd2:    digit_sel = snap2_d;
            default: digit_sel = snap3_d;
        endcase

        seg_d = tick ? hex_to_seg(digit_sel) : seg_q;

        // A slot opens with one blank clock (blank_q), then lights its anode.
        // After an EN pause the anodes stay dark until the next tick, since
        // blank_q is only set by a tick.
        if (!EN || tick) begin
            an_d = 4'b1111;
        end else if (blank_q) begin
            an_d = ~(4'b0001 << idx_q);
        end else begin
            an_d = an_q;
        end

`ifdef SEG7_MISMATCH_DP_EN
        mism_d = snap_load ? ((D0 != D2) || (D1 != D3)) : mism_q;
        dp_d   = EN ? ~(mism_q && (an_d != 4'b1111)) : dp_q;
`else
        dp_d   = 1'b1;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcnt_q  <= '0;
            idx_q   <= 2'd0;
            snap0_q <= 4'h0;
            snap1_q <= 4'h0;
            snap2_q <= 4'h0;
            snap3_q <= 4'h0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
            blank_q <= 1'b0;
`ifdef SEG7_MISMATCH_DP_EN
            mism_q  <= 1'b0;
`endif
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            snap0_q <= snap0_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            snap3_q <= snap3_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
            blank_q <= blank_d;
`ifdef SEG7_MISMATCH_DP_EN
            mism_q  <= mism_d;
`endif
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan4 - scoreboard bench for seg7_scan4
//
// Main DUT runs with DIV=4; a second DUT with DIV=2 shares all inputs and is
// checked against a short hand table right after reset. The stimulus process
// pushes the expected contents of every lit digit slot; the monitor pops one
// entry each time an anode lights after a blank cycle.
// Cycle numbers: cyc==n at the falling edge that follows rising edge n after
// reset release.
// ---------------------------------------------------------------------------
module tb_seg7_scan4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] D0, D1, D2, D3;
    logic [3:0] AN,  AN2;
    logic [6:0] SEG, SEG2;
    logic       DP,  DP2;
    logic       FRAME, FRAME2;

    seg7_scan4 #(.DIV(4), .PW(3)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
    );

    seg7_scan4 #(.DIV(2), .PW(1)) dut2 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .AN(AN2), .SEG(SEG2), .DP(DP2), .FRAME(FRAME2)
    );

    always #5 CLK = ~CLK;

`ifdef SEG7_MISMATCH_DP_EN
    localparam bit USE_MISM = 1'b1;
`else
    localparam bit USE_MISM = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int frame_log[$];

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       one_blank;
    } slot_t;

    slot_t exp_q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (!RST && FRAME) frame_log.push_back(cyc);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic dp_lit(input logic mm);
        return USE_MISM ? ~mm : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_slot(input int idx, input logic [3:0] val, input logic mm, input logic ob);
        slot_t e;
        e.an        = ~(4'b0001 << idx);
        e.seg       = seg_of(val);
        e.dp        = dp_lit(mm);
        e.one_blank = ob;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, n);
        end
    endtask

    task automatic chk_frames(input int n, input int f0, input int f1, input int f2,
                              input int f3, input int f4);
        int e[5];
        e = '{f0, f1, f2, f3, f4};
        chk("frame_count", frame_log.size(), n);
        for (int i = 0; i < n && i < frame_log.size(); i++)
            chk("frame_cycle", frame_log[i], e[i]);
    endtask

    // Slot monitor
    logic [3:0] an_prev;
    int         blank_run;
    always @(negedge CLK) begin
        slot_t e;
        if (RST) begin
            an_prev   = 4'b1111;
            blank_run = 0;
        end else begin
            if (AN != 4'b1111 && an_prev == 4'b1111) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_unexpected: got an=%b seg=%b dp=%b expected none (cyc %0d)",
                             AN, SEG, DP, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({AN, SEG, DP} !== {e.an, e.seg, e.dp}) begin
                        errors++;
                        $display("FAIL slot: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b (cyc %0d)",
                                 AN, SEG, DP, e.an, e.seg, e.dp, cyc);
                    end
                    if (e.one_blank) begin
                        checks++;
                        if (blank_run != 1) begin
                            errors++;
                            $display("FAIL blank_len: got %0d expected 1 (cyc %0d)", blank_run, cyc);
                        end
                    end
                end
            end else if (AN != 4'b1111 && AN != an_prev) begin
                checks++;
                errors++;
                $display("FAIL slot_no_blank: got an=%b after %b expected 1111 between (cyc %0d)",
                         AN, an_prev, cyc);
            end
            if (AN == 4'b1111) blank_run = blank_run + 1;
            else               blank_run = 0;
            an_prev = AN;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] an2_tab [1:9];
        an2_tab = '{4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1011,
                    4'b1111, 4'b0111, 4'b1111, 4'b1110};

        RST = 1'b1; EN = 1'b1;
        D0 = 4'h5; D1 = 4'hA; D2 = 4'h5; D3 = 4'hA;
        repeat (2) @(negedge CLK);
        chk("rst_an",    AN,    4'b1111);
        chk("rst_seg",   SEG,   7'b1111111);
        chk("rst_dp",    DP,    1'b1);
        chk("rst_frame", FRAME, 1'b0);
        chk("rst_an2",   AN2,   4'b1111);
        RST = 1'b0;

        // First frame shows the reset snapshot (0000), then 5 A 5 A.
        push_slot(1, 4'h0, 1'b0, 1'b0);
        push_slot(2, 4'h0, 1'b0, 1'b1);
        push_slot(3, 4'h0, 1'b0, 1'b1);
        push_slot(0, 4'h5, 1'b0, 1'b1);
        push_slot(1, 4'hA, 1'b0, 1'b1);
        push_slot(2, 4'h5, 1'b0, 1'b1);
        push_slot(3, 4'hA, 1'b0, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            wait_cyc(c);
            if (c <= 4) chk("an_before_first_tick", AN, 4'b1111);
            if (c <= 9) chk("div2_an", AN2, an2_tab[c]);
            if (c == 8) chk("div2_frame", FRAME2, 1'b1);
            if (c == 9) begin
                chk("div2_seg", SEG2, seg_of(4'h5));
                chk("div2_dp",  DP2,  dp_lit(1'b0));
            end
            if (c == 16) begin
                chk("wrap_blank_an",  AN,  4'b1111);
                chk("wrap_blank_seg", SEG, seg_of(4'h5));
            end
        end
        chk("queue_drained_p1", exp_q.size(), 0);
        chk_frames(1, 16, 0, 0, 0, 0);

        // Full-frame sweep 1 2 3 F, captured at cyc 32.
        D0 = 4'h1; D1 = 4'h2; D2 = 4'h3; D3 = 4'hF;
        push_slot(0, 4'h1, 1'b1, 1'b1);
        push_slot(1, 4'h2, 1'b1, 1'b1);
        push_slot(2, 4'h3, 1'b1, 1'b1);
        push_slot(3, 4'hF, 1'b1, 1'b1);

        // Snapshot isolation: D1 changes during idx 1, visible next frame.
        wait_cyc(46);
        push_slot(0, 4'h1, 1'b1, 1'b1);
        push_slot(1, 4'h2, 1'b1, 1'b1);
        push_slot(2, 4'h3, 1'b1, 1'b1);
        push_slot(3, 4'hF, 1'b1, 1'b1);
        push_slot(0, 4'h1, 1'b1, 1'b1);
        push_slot(1, 4'h7, 1'b1, 1'b1);
        push_slot(2, 4'h3, 1'b1, 1'b1);
        push_slot(3, 4'hF, 1'b1, 1'b1);
        wait_cyc(52);
        D1 = 4'h7;
        wait_cyc(78);
        chk("queue_drained_p3", exp_q.size(), 0);

        // EN pause for 10 clocks with pcnt at 2 in the idx 3 slot.
        EN = 1'b0;
        push_slot(0, 4'h1, 1'b1, 1'b0);
        push_slot(1, 4'h7, 1'b1, 1'b1);
        push_slot(2, 4'h3, 1'b1, 1'b1);
        push_slot(3, 4'hF, 1'b1, 1'b1);
        wait_cyc(79);
        chk("pause_an",  AN,  4'b1111);
        chk("pause_seg", SEG, seg_of(4'hF));
        chk("pause_dp",  DP,  dp_lit(1'b1));
        wait_cyc(85);
        chk("pause_an_mid", AN, 4'b1111);
        wait_cyc(88);
        EN = 1'b1;
        wait_cyc(89);
        chk("resume_an_dark", AN, 4'b1111);
        wait_cyc(90);
        chk("resume_blank", AN, 4'b1111);
        wait_cyc(91);
        chk("resume_lit", AN, 4'b1110);
        wait_cyc(104);
        chk("queue_drained_p4", exp_q.size(), 0);
        chk_frames(5, 16, 32, 48, 64, 90);

        // Async reset between edges while FRAME is high.
        wait_cyc(106);
        chk("frame_before_rst", FRAME, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_an",    AN,    4'b1111);
        chk("async_rst_seg",   SEG,   7'b1111111);
        chk("async_rst_frame", FRAME, 1'b0);
        chk("async_rst_dp",    DP,    1'b1);
        D0 = 4'h9; D1 = 4'h9; D2 = 4'h9; D3 = 4'h9;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        frame_log.delete();

        push_slot(1, 4'h0, 1'b0, 1'b0);
        push_slot(2, 4'h0, 1'b0, 1'b1);
        push_slot(3, 4'h0, 1'b0, 1'b1);
        push_slot(0, 4'h9, 1'b0, 1'b1);
        push_slot(1, 4'h9, 1'b0, 1'b1);
        push_slot(2, 4'h9, 1'b0, 1'b1);
        push_slot(3, 4'h9, 1'b0, 1'b1);
        push_slot(0, 4'h3, 1'b1, 1'b1);
        push_slot(1, 4'h9, 1'b1, 1'b1);
        push_slot(2, 4'h4, 1'b1, 1'b1);
        push_slot(3, 4'h9, 1'b1, 1'b1);
        push_slot(0, 4'h3, 1'b0, 1'b1);
        push_slot(1, 4'h9, 1'b0, 1'b1);
        push_slot(2, 4'h3, 1'b0, 1'b1);
        push_slot(3, 4'h9, 1'b0, 1'b1);

        // Mismatch D0!=D2 captured at cyc 32, cleared by the cyc 48 capture.
        wait_cyc(18);
        D0 = 4'h3; D2 = 4'h4;
        wait_cyc(34);
        D2 = 4'h3;
        wait_cyc(35);
        chk("mism_dp_lit", DP, dp_lit(1'b1));
        wait_cyc(36);
        chk("mism_blank_an", AN, 4'b1111);
        chk("mism_blank_dp", DP, 1'b1);
        wait_cyc(62);
        chk("queue_drained_p6", exp_q.size(), 0);
        chk_frames(3, 16, 32, 48, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
